fetch_unit: RTL and testbench

- Instruction fetch sequencer that sits directly downstream of the program counter register.
- Samples PC on a fetch command and drives a request/ready memory read at that address.
- Latches the returned word into the instruction register (IR).
- Then issues the one-cycle PC load/increment strobe (ldPC with selPC=2'b00) back to the PC stage.

---
 rtl/fetch_unit.sv | 154 +++++++++++++++
 tb/tb_fetch_unit.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit -- instruction fetch sequencer placed after the program counter.
//
// A fetch command in IDLE captures PC into MAR and raises a memory read
// request.  When memory answers, the returned word is loaded into IR and a
// one-cycle ldPC strobe (selPC = PC+1) is sent back to the PC stage.
//
// Optional feature macro: FETCH_TIMEOUT_EN
//   defined   : a fetch left waiting TIMEOUT_CYCLES REQ cycles is abandoned
//               and fetch_err pulses for one cycle.
//   undefined : REQ waits indefinitely, fetch_err is tied low.
//
// Ports:
//   clk          in   system clock, rising edge
//   reset        in   asynchronous active-low reset
//   start_fetch  in   fetch command, sampled only in IDLE
//   PC           in   current program counter
//   mem_rdy      in   read data valid, sampled only in REQ
//   mem_rdata    in   read data
//   mem_req      out  memory read request
//   mem_addr     out  read address (MAR)
//   IR           out  instruction register
//   ldPC         out  PC load strobe
//   selPC        out  PC mux select, always PC+1 (2'b00)
//   busy         out  high outside IDLE
//   fetch_done   out  one-cycle pulse when IR holds the new instruction
//   fetch_err    out  one-cycle timeout pulse

module fetch_unit #(
    parameter int DATA_W         = 16,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_fetch,
    input  logic [DATA_W-1:0] PC,
    input  logic              mem_rdy,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mem_req,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] IR,
    output logic              ldPC,
    output logic [1:0]        selPC,
    output logic              busy,
    output logic              fetch_done,
    output logic              fetch_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_REQ  = 2'b01,
        S_INCR = 2'b10
    } state_t;

    state_t            r_state;
    logic [DATA_W-1:0] r_mar;
    logic [DATA_W-1:0] r_ir;
    logic              r_mem_req;
    logic              r_busy;
    logic              r_ldpc;
    logic              r_done;
    logic              w_accept;

`ifdef FETCH_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] r_cnt;
    logic        r_err;

    // The IDLE cycle that carries fetch_err must not start a new fetch.
    assign w_accept  = start_fetch && !r_err;
    assign fetch_err = r_err;
`else
    logic w_unused_timeout;

    assign w_unused_timeout = (TIMEOUT_CYCLES != 0);
    assign w_accept         = start_fetch;
    assign fetch_err        = 1'b0;
`endif

    // All outputs come straight from registers updated with the state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_mar     <= '0;
            r_ir      <= '0;
            r_mem_req <= 1'b0;
            r_busy    <= 1'b0;
            r_ldpc    <= 1'b0;
            r_done    <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
            r_cnt     <= '0;
            r_err     <= 1'b0;
`endif
        end else begin
            // Strobes are single-cycle unless re-armed below.
            r_ldpc <= 1'b0;
            r_done <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
            r_err  <= 1'b0;
`endif
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_mar     <= PC;
                        r_state   <= S_REQ;
                        r_mem_req <= 1'b1;
                        r_busy    <= 1'b1;
`ifdef FETCH_TIMEOUT_EN
                        r_cnt     <= '0;
`endif
                    end
                end
                S_REQ: begin
                    // A response on the timeout edge still wins.
                    if (mem_rdy) begin
                        r_ir      <= mem_rdata;
                        r_state   <= S_INCR;
                        r_mem_req <= 1'b0;
                        r_ldpc    <= 1'b1;
                        r_done    <= 1'b1;
                    end
`ifdef FETCH_TIMEOUT_EN
                    else if (r_cnt == TO_LAST) begin
                        r_state   <= S_IDLE;
                        r_mem_req <= 1'b0;
                        r_busy    <= 1'b0;
                        r_err     <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
`endif
                end
                S_INCR: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_mem_req <= 1'b0;
                    r_busy    <= 1'b0;
                end
            endcase
        end
    end

    assign mem_req    = r_mem_req;
    assign mem_addr   = r_mar;
    assign IR         = r_ir;
    assign ldPC       = r_ldpc;
    assign selPC      = 2'b00;
    assign busy       = r_busy;
    assign fetch_done = r_done;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    localparam int TO = 4;
`ifdef FETCH_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        start_fetch;
    logic [15:0] PC;
    logic        mem_rdy;
    logic [15:0] mem_rdata;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic [15:0] IR;
    logic        ldPC;
    logic [1:0]  selPC;
    logic        busy;
    logic        fetch_done;
    logic        fetch_err;

    int n_chk = 0;
    int n_bad = 0;
    logic [15:0] exp_ir;

    fetch_unit #(.DATA_W(16), .TIMEOUT_CYCLES(TO)) dut (
        .clk        (clk),
        .reset      (reset),
        .start_fetch(start_fetch),
        .PC         (PC),
        .mem_rdy    (mem_rdy),
        .mem_rdata  (mem_rdata),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .IR         (IR),
        .ldPC       (ldPC),
        .selPC      (selPC),
        .busy       (busy),
        .fetch_done (fetch_done),
        .fetch_err  (fetch_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Outputs expected in an idle cycle with no pending strobe.
    task automatic chk_idle(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_req"}, mem_req, 0);
        chk({tag, "_ldpc"}, ldPC, 0);
        chk({tag, "_done"}, fetch_done, 0);
        chk({tag, "_err"}, fetch_err, 0);
        chk({tag, "_ir"}, IR, exp_ir);
    endtask

    // Called at a negedge inside an IDLE cycle. Issues one fetch of pc,
    // memory answers with data after `delay` extra REQ cycles.  PC input is
    // switched to pc_mid once the fetch has started; start_fetch is held
    // high throughout when hold=1 and is left at hold on return.
    task automatic do_fetch(input logic [15:0] pc, input logic [15:0] data,
                            input int delay, input bit hold, input logic [15:0] pc_mid);
        bit timed_out;
        int n_req;
        timed_out = TO_EN && (delay >= TO);
        n_req     = timed_out ? TO : delay + 1;
        start_fetch = 1'b1;
        PC          = pc;
        mem_rdy     = 1'b0;
        mem_rdata   = 16'($urandom);
        @(negedge clk);
        for (int k = 0; k < n_req; k++) begin
            chk("req", mem_req, 1);
            chk("addr", mem_addr, pc);
            chk("req_busy", busy, 1);
            chk("req_ldpc", ldPC, 0);
            chk("req_done", fetch_done, 0);
            chk("req_err", fetch_err, 0);
            chk("req_ir", IR, exp_ir);
            start_fetch = hold ? 1'b1 : 1'($urandom);
            PC          = pc_mid;
            mem_rdy     = (!timed_out && k == delay);
            mem_rdata   = mem_rdy ? data : 16'($urandom);
            @(negedge clk);
        end
        if (timed_out) begin
            chk("to_err", fetch_err, 1);
            chk("to_busy", busy, 0);
            chk("to_req", mem_req, 0);
            chk("to_ldpc", ldPC, 0);
            chk("to_done", fetch_done, 0);
            chk("to_ir", IR, exp_ir);
            start_fetch = 1'b1;
            mem_rdy     = 1'($urandom);
            @(negedge clk);
            chk_idle("after_to");
        end else begin
            exp_ir = data;
            chk("incr_ldpc", ldPC, 1);
            chk("incr_sel", selPC, 0);
            chk("incr_done", fetch_done, 1);
            chk("incr_req", mem_req, 0);
            chk("incr_busy", busy, 1);
            chk("incr_err", fetch_err, 0);
            chk("incr_ir", IR, exp_ir);
            start_fetch = 1'b1;
            mem_rdy     = 1'($urandom);
            mem_rdata   = 16'($urandom);
            @(negedge clk);
            chk_idle("after_incr");
        end
        start_fetch = hold;
        mem_rdy     = 1'b0;
    endtask

    initial begin
        reset       = 1'b0;
        start_fetch = 1'b0;
        PC          = 16'h0000;
        mem_rdy     = 1'b0;
        mem_rdata   = 16'h0000;
        exp_ir      = 16'h0000;

        #1;
        chk("rst_addr", mem_addr, 0);
        chk("rst_sel", selPC, 0);
        chk_idle("rst");
        repeat (3) @(negedge clk);
        reset = 1'b1;

        // Idle after reset release.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk_idle("idle5");
        end

        // Single zero-wait fetch.
        do_fetch(16'h3000, 16'h1261, 0, 1'b0, 16'h3000);

        // Delayed response, PC moves mid-REQ, start held high: one fetch of
        // FFFF, then a new fetch from 1234 right after the idle cycle.
        do_fetch(16'hFFFF, 16'hF025, 7, 1'b1, 16'h1234);
        do_fetch(16'h1234, 16'hBEEF, 1, 1'b0, 16'h1234);

        // Reset in the middle of a REQ.
        start_fetch = 1'b1;
        PC          = 16'h4000;
        @(negedge clk);
        chk("pre_rst_req", mem_req, 1);
        chk("pre_rst_addr", mem_addr, 16'h4000);
        #2;
        reset = 1'b0;
        #1;
        exp_ir = 16'h0000;
        chk("mid_rst_addr", mem_addr, 0);
        chk_idle("mid_rst");
        start_fetch = 1'b0;
        mem_rdy     = 1'b1;
        @(negedge clk);
        chk_idle("rst_hold");
        mem_rdy = 1'b0;
        reset   = 1'b1;
        @(negedge clk);
        chk_idle("rst_rel");
        do_fetch(16'h4000, 16'h5A5A, 2, 1'b0, 16'h4001);

        // Timeout boundary: no response, then a response on the last cycle.
        do_fetch(16'h0777, 16'h1111, 100, 1'b0, 16'h0778);
        do_fetch(16'h0779, 16'h2222, TO - 1, 1'b0, 16'h077A);

        // Randomized fetches separated by noisy idle gaps.
        for (int i = 0; i < 30; i++) begin
            do_fetch(16'($urandom), 16'($urandom), $urandom_range(0, 6), 1'b0, 16'($urandom));
            for (int g = 0; g < int'($urandom_range(0, 3)); g++) begin
                mem_rdy   = 1'($urandom);
                mem_rdata = 16'($urandom);
                @(negedge clk);
                chk_idle("gap");
            end
            mem_rdy = 1'b0;
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
